ir_compressor: RTL and testbench



---
 rtl/ir_compressor.sv | 230 +++++++++++++++++++++++
 tb/tb_ir_compressor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_compressor.sv
// ir_compressor: re-encodes retired RV32 instructions to RVC where an exact
// 16-bit equivalent exists, then packs 16/32-bit parcels little-endian into a
// 32-bit word stream for the trace memory.
// Optional macro IR_COMPRESS_JUMP_EN also compresses jal/beq/bne.
module ir_compressor #(
   parameter int CNT_WIDTH       = 16,
   parameter int ENABLE_COMPRESS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_word,
   output logic                 idle,
   output logic [CNT_WIDTH-1:0] cnt_in,
   output logic [CNT_WIDTH-1:0] cnt_comp
);
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
`ifdef IR_COMPRESS_JUMP_EN
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] BRANCH = 7'b1100011;
`endif

   logic               hold_v;
   logic [15:0]        hold;
   logic               accept, fire_flush, is_parcel, is16, comp_ok;
   logic [15:0]        comp16, p16;
   logic [6:0]         opc, f7;
   logic [4:0]         rd, rs1, rs2;
   logic [2:0]         f3;
   logic               rd_p, rs1_p, rs2_p;
   logic signed [11:0] imm_i, imm_s;
   logic signed [19:0] imm_u;
`ifdef IR_COMPRESS_JUMP_EN
   logic signed [20:0] imm_j;
   logic signed [12:0] imm_b;
`endif

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic fits6(input logic signed [11:0] v);
      return (v >= -12'sd32) && (v <= 12'sd31);
   endfunction

   assign opc   = in_instr[6:0];
   assign rd    = in_instr[11:7];
   assign f3    = in_instr[14:12];
   assign rs1   = in_instr[19:15];
   assign rs2   = in_instr[24:20];
   assign f7    = in_instr[31:25];
   assign imm_i = in_instr[31:20];
   assign imm_s = {in_instr[31:25], in_instr[11:7]};
   assign imm_u = in_instr[31:12];
   assign rd_p  = (rd[4:3] == 2'b01);
   assign rs1_p = (rs1[4:3] == 2'b01);
   assign rs2_p = (rs2[4:3] == 2'b01);
`ifdef IR_COMPRESS_JUMP_EN
   assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
`endif

   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign fire_flush = flush && hold_v && !accept && in_ready;
   assign idle       = !hold_v && !out_valid;
   assign is_parcel  = (in_instr[1:0] != 2'b11);
   assign is16       = is_parcel || (comp_ok && (ENABLE_COMPRESS != 0));
   assign p16        = is_parcel ? in_instr[15:0] : comp16;

   // Find the exact RVC equivalent of the incoming 32-bit instruction, if any.
   always_comb begin
      comp_ok = 1'b0;
      comp16  = 16'h0000;
      case (opc)
         OP_IMM: begin
            if (f3 == 3'b000) begin
               if (rd == rs1 && rd != 5'd0 && fits6(imm_i) && imm_i != 12'sd0) begin
                  comp_ok = 1'b1; comp16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
               end else if (rd != 5'd0 && rs1 == 5'd0 && fits6(imm_i)) begin
                  comp_ok = 1'b1; comp16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
               end else if (rd == 5'd2 && rs1 == 5'd2 && imm_i[3:0] == 4'd0 &&
                            imm_i >= -12'sd512 && imm_i <= 12'sd496 && imm_i != 12'sd0) begin
                  comp_ok = 1'b1;
                  comp16  = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
               end else if (rd_p && rs1 == 5'd2 && imm_i[1:0] == 2'd0 &&
                            imm_i >= 12'sd4 && imm_i <= 12'sd1020) begin
                  comp_ok = 1'b1;
                  comp16  = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
               end
            end else if (f3 == 3'b001 && f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
               comp_ok = 1'b1; comp16 = {3'b000, 1'b0, rd, rs2, 2'b10};
            end else if (f3 == 3'b101 && rd == rs1 && rd_p && rs2 != 5'd0 &&
                         (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
               comp_ok = 1'b1; comp16 = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
            end else if (f3 == 3'b111 && rd == rs1 && rd_p && fits6(imm_i)) begin
               comp_ok = 1'b1; comp16 = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
            end
         end
         OP_REG: begin
            if (f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
               comp_ok = 1'b1; comp16 = {4'b1000, rd, rs2, 2'b10};
            end else if (f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0 && rd == rs1) begin
               comp_ok = 1'b1; comp16 = {4'b1001, rd, rs2, 2'b10};
            end else if (rd == rs1 && rd_p && rs2_p) begin
               if (f3 == 3'b000 && f7 == 7'b0100000) begin
                  comp_ok = 1'b1; comp16 = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
               end else if (f3 == 3'b100 && f7 == 7'd0) begin
                  comp_ok = 1'b1; comp16 = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
               end else if (f3 == 3'b110 && f7 == 7'd0) begin
                  comp_ok = 1'b1; comp16 = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
               end else if (f3 == 3'b111 && f7 == 7'd0) begin
                  comp_ok = 1'b1; comp16 = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
               end
            end
         end
         LOAD: begin
            if (f3 == 3'b010 && imm_i[1:0] == 2'd0 && imm_i >= 12'sd0) begin
               if (rs1 == 5'd2 && rd != 5'd0 && imm_i <= 12'sd252) begin
                  comp_ok = 1'b1; comp16 = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
               end else if (rd_p && rs1_p && imm_i <= 12'sd124) begin
                  comp_ok = 1'b1;
                  comp16  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
               end
            end
         end
         STORE: begin
            if (f3 == 3'b010 && imm_s[1:0] == 2'd0 && imm_s >= 12'sd0) begin
               if (rs1 == 5'd2 && imm_s <= 12'sd252) begin
                  comp_ok = 1'b1; comp16 = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
               end else if (rs1_p && rs2_p && imm_s <= 12'sd124) begin
                  comp_ok = 1'b1;
                  comp16  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
               end
            end
         end
         JALR: begin
            if (f3 == 3'b000 && (rd == 5'd0 || rd == 5'd1) && rs1 != 5'd0 && imm_i == 12'sd0) begin
               comp_ok = 1'b1; comp16 = {3'b100, rd[0], rs1, 5'd0, 2'b10};
            end
         end
         LUI: begin
            if (rd != 5'd0 && rd != 5'd2 && imm_u >= -20'sd32 && imm_u <= 20'sd31 && imm_u != 20'sd0) begin
               comp_ok = 1'b1; comp16 = {3'b011, imm_u[5], rd, imm_u[4:0], 2'b01};
            end
         end
         SYSTEM: begin
            if (in_instr == 32'h0010_0073) begin
               comp_ok = 1'b1; comp16 = 16'h9002;
            end
         end
`ifdef IR_COMPRESS_JUMP_EN
         // Offsets are copied verbatim: the trace reader expands them back unchanged.
         JAL: begin
            if ((rd == 5'd0 || rd == 5'd1) && imm_j >= -21'sd2048 && imm_j <= 21'sd2046) begin
               comp_ok = 1'b1;
               comp16  = {(rd[0] ? 3'b001 : 3'b101), imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
                          imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
            end
         end
         BRANCH: begin
            if ((f3 == 3'b000 || f3 == 3'b001) && rs2 == 5'd0 && rs1_p &&
                imm_b >= -13'sd256 && imm_b <= 13'sd254) begin
               comp_ok = 1'b1;
               comp16  = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6],
                          imm_b[2:1], imm_b[5], 2'b01};
            end
         end
`endif
         default: ;
      endcase
   end

   // Pack parcels into the one-entry output register; an accepted input beats flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_word  <= 32'h0;
         hold_v    <= 1'b0;
         hold      <= 16'h0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept) begin
            if (is16) begin
               if (hold_v) begin
                  out_word  <= {p16, hold};
                  out_valid <= 1'b1;
                  hold_v    <= 1'b0;
               end else begin
                  hold   <= p16;
                  hold_v <= 1'b1;
               end
            end else if (hold_v) begin
               out_word  <= {in_instr[15:0], hold};
               hold      <= in_instr[31:16];
               out_valid <= 1'b1;
            end else begin
               out_word  <= in_instr;
               out_valid <= 1'b1;
            end
         end else if (fire_flush) begin
            out_word  <= {16'h0001, hold};
            out_valid <= 1'b1;
            hold_v    <= 1'b0;
         end
      end
   end

   // Saturating statistics on every accepted instruction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_in   <= '0;
         cnt_comp <= '0;
      end else if (accept) begin
         cnt_in <= sat_inc(cnt_in);
         if (is16) cnt_comp <= sat_inc(cnt_comp);
      end
   end
endmodule

// File: tb/tb_ir_compressor.sv
// tb_ir_compressor: directed bench for ir_compressor (counters narrowed to 4 bits
// so saturation is reachable quickly).
module tb_ir_compressor;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, flush, out_valid, out_ready, idle;
   logic [31:0]   in_instr, out_word;
   logic [CW-1:0] cnt_in, cnt_comp;
   int            checks = 0;
   int            errors = 0;

   localparam logic [31:0] TI [12] = '{
      32'hFFF00513, 32'h00329293, 32'h00B00533, 32'h40940433,
      32'h00412083, 32'h00942423, 32'h00008067, 32'hFC010113,
      32'h01010413, 32'hFE050513, 32'hFFFFF537, 32'h40245413};
   localparam logic [15:0] TC [12] = '{
      16'h557D, 16'h028E, 16'h852E, 16'h8C05,
      16'h4092, 16'hC404, 16'h8082, 16'h7139,
      16'h0800, 16'h1501, 16'h757D, 16'h8409};
   localparam logic [31:0] SW [4] = '{
      32'h05090505, 32'h0511050D, 32'h05190515, 32'h0521051D};

   always #5 clk = ~clk;

   ir_compressor #(.CNT_WIDTH(CW), .ENABLE_COMPRESS(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_word(out_word), .idle(idle),
      .cnt_in(cnt_in), .cnt_comp(cnt_comp));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = 32'h0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = 32'h0;
      cyc(); cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL rst_out_word got %h exp 0", out_word); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
      checks++; if (cnt_in !== 4'd0 || cnt_comp !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", cnt_in, cnt_comp); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_pair();
      in_valid = 1'b1; in_instr = 32'h00150513;
      cyc();
      checks++; if (out_valid !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL pair_hold got v=%b idle=%b exp v=0 idle=0", out_valid, idle); end
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h05050505) begin errors++; $display("FAIL pair_word got %b/%h exp 1/05050505", out_valid, out_word); end
      checks++; if (cnt_in !== 4'd2 || cnt_comp !== 4'd2) begin errors++; $display("FAIL pair_cnt got %0d/%0d exp 2/2", cnt_in, cnt_comp); end
      cyc();
      checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL pair_drain got v=%b idle=%b exp 0/1", out_valid, idle); end
   endtask

   task automatic test_lui_flush();
      in_valid = 1'b1; in_instr = 32'h00150513;
      cyc();
      in_instr = 32'h123452B7; flush = 1'b1;   // accepted word must win over flush
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h52B70505) begin errors++; $display("FAIL lui_word got %b/%h exp 1/52b70505", out_valid, out_word); end
      cyc();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h00011234) begin errors++; $display("FAIL lui_pad got %b/%h exp 1/00011234", out_valid, out_word); end
      cyc();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL lui_idle got %b exp 1", idle); end
   endtask

   task automatic test_uncompressible();
      do_reset();
      in_valid = 1'b1; in_instr = 32'h003100B3;
      cyc();
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h003100B3) begin errors++; $display("FAIL add_word got %b/%h exp 1/003100b3", out_valid, out_word); end
      checks++; if (cnt_in !== 4'd1 || cnt_comp !== 4'd0) begin errors++; $display("FAIL add_cnt got %0d/%0d exp 1/0", cnt_in, cnt_comp); end
      in_instr = 32'h00100073;
      cyc();
      in_valid = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h00019002) begin errors++; $display("FAIL ebreak_word got %b/%h exp 1/00019002", out_valid, out_word); end
      in_valid = 1'b1; in_instr = 32'h02050513;   // addi imm=32: just out of c.addi range
      cyc();
      checks++; if (out_word !== 32'h02050513) begin errors++; $display("FAIL addi32_word got %h exp 02050513", out_word); end
      in_instr = 32'h08942023;                    // sw offset 128: just out of c.sw range
      cyc();
      in_valid = 1'b0;
      checks++; if (out_word !== 32'h08942023) begin errors++; $display("FAIL sw128_word got %h exp 08942023", out_word); end
      checks++; if (cnt_in !== 4'd4 || cnt_comp !== 4'd1) begin errors++; $display("FAIL unc_cnt got %0d/%0d exp 4/1", cnt_in, cnt_comp); end
      cyc();
   endtask

   task automatic test_compress_table();
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_instr = TI[i];
         cyc();
         in_valid = 1'b0; flush = 1'b1;
         cyc();
         flush = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_word !== {16'h0001, TC[i]}) begin
            errors++; $display("FAIL table_%0d instr %h got %b/%h exp 1/0001%h", i, TI[i], out_valid, out_word, TC[i]);
         end
      end
      cyc();
   endtask

   task automatic test_stall();
      int ntx = 0;
      int nrx = 0;
      logic acc, snk, stall;
      logic [31:0] held;
      do_reset();
      for (int c = 0; c < 40 && nrx < 4; c++) begin
         out_ready = !(c >= 3 && c < 8);
         in_valid  = (ntx < 8);
         in_instr  = 32'h00050513 | (32'(ntx + 1) << 20);
         #1;
         if (out_valid && !out_ready) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b exp 0", c, in_ready); end
         end
         acc   = in_valid && in_ready;
         snk   = out_valid && out_ready;
         stall = out_valid && !out_ready;
         held  = out_word;
         if (snk) begin
            checks++; if (out_word !== SW[nrx]) begin errors++; $display("FAIL stall_word_%0d got %h exp %h", nrx, out_word, SW[nrx]); end
            nrx++;
         end
         cyc();
         if (acc) ntx++;
         if (stall) begin
            checks++; if (out_valid !== 1'b1 || out_word !== held) begin errors++; $display("FAIL stall_hold cycle %0d got %b/%h exp 1/%h", c, out_valid, out_word, held); end
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (nrx != 4 || ntx != 8) begin errors++; $display("FAIL stall_count got rx=%0d tx=%0d exp 4/8", nrx, ntx); end
      cyc();
      checks++; if (idle !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra got idle=%b v=%b exp 1/0", idle, out_valid); end
      checks++; if (cnt_in !== 4'd8 || cnt_comp !== 4'd8) begin errors++; $display("FAIL stall_cnt got %0d/%0d exp 8/8", cnt_in, cnt_comp); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00150513;
      cyc();
      in_instr = 32'h123452B7;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || idle !== 1'b0) begin errors++; $display("FAIL mid_pending got v=%b idle=%b exp 1/0", out_valid, idle); end
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || out_word !== 32'h0) begin errors++; $display("FAIL mid_rst got v=%b idle=%b w=%h exp 0/1/0", out_valid, idle, out_word); end
      checks++; if (cnt_in !== 4'd0 || cnt_comp !== 4'd0) begin errors++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", cnt_in, cnt_comp); end
      out_ready = 1'b1; flush = 1'b1;
      cyc(); cyc();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL mid_flush got v=%b idle=%b exp 0/1", out_valid, idle); end
   endtask

   task automatic test_jump();
      do_reset();
      in_valid = 1'b1; in_instr = 32'hFFDFF06F;
      cyc();
`ifdef IR_COMPRESS_JUMP_EN
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jal_held got %b exp 0", out_valid); end
      in_instr = 32'h00150513;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h0505BFF5) begin errors++; $display("FAIL jal_word got %b/%h exp 1/0505bff5", out_valid, out_word); end
`else
      checks++; if (out_valid !== 1'b1 || out_word !== 32'hFFDFF06F) begin errors++; $display("FAIL jal_word got %b/%h exp 1/ffdff06f", out_valid, out_word); end
      in_instr = 32'h00150513;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL jal_hold got v=%b idle=%b exp 0/0", out_valid, idle); end
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      checks++; if (out_word !== 32'h00010505) begin errors++; $display("FAIL jal_pad got %h exp 00010505", out_word); end
`endif
      cyc();
   endtask

   task automatic test_saturation();
      do_reset();
      in_valid = 1'b1; in_instr = 32'hDEAD4505;   // already a parcel; upper half ignored
      cyc(); cyc();
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h45054505) begin errors++; $display("FAIL parcel_word got %b/%h exp 1/45054505", out_valid, out_word); end
      repeat (18) cyc();
      in_valid = 1'b0;
      checks++; if (cnt_in !== 4'hF || cnt_comp !== 4'hF) begin errors++; $display("FAIL sat_cnt got %0d/%0d exp 15/15", cnt_in, cnt_comp); end
      cyc();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL sat_idle got %b exp 1", idle); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_pair();
      test_lui_flush();
      test_uncompressible();
      test_compress_table();
      test_stall();
      test_reset_mid();
      test_jump();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
